bullet_pool: RTL

Parametrised player-bullet manager, successor to the fixed single/double bullet block.
- Keeps a pool of BULLET_NUM slots and fires 1, 2 or 3 lanes per fire event into the lowest free slots.
- Advances bullets once per frame tick; retires them on screen exit or on a kill from collision logic.
- Answers registered VGA pixel queries with alpha, colour and the covering slot index.
- Sits between the player plane position source and the VGA compositor/collision unit.

---
 rtl/bullet_pool_pkg.sv | 64 ++++++
 rtl/bullet_pool_if.sv | 42 ++++
 rtl/bullet_pool_free_finder.sv | 50 +++++
 rtl/bullet_pool.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bullet_pool_pkg.sv
//------------------------------------------------------------------------------
// Module   : bullet_pool_pkg
// Purpose  : Shared display/sprite macros, lane tables, lane-mode codes and
//            small helpers used by the bullet pool, its interface and bench.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef BULLET_POOL_DEFINES
`define BULLET_POOL_DEFINES
`define H_DISP              640
`define V_DISP              480
`define H_DISP_LEN          10
`define V_DISP_LEN          10
`define OBJ_X_POS_BIT_LEN   10
`define OBJ_Y_POS_BIT_LEN   10
`define COLOR_RGB_DEPTH     12
`define BULLET_SINGLE_COLOR 12'hFF0
`define BULLET_WIDTH        4
`define BULLET_HEIGHT       8
`define BULLET_MODE_SINGLE  2'd0
`define BULLET_MODE_DOUBLE  2'd1
`define BULLET_MODE_TRIPLE  2'd2
`endif

package bullet_pool_pkg;

  localparam int X_W    = `OBJ_X_POS_BIT_LEN;
  localparam int Y_W    = `OBJ_Y_POS_BIT_LEN;
  localparam int H_LEN  = `H_DISP_LEN;
  localparam int V_LEN  = `V_DISP_LEN;
  localparam int RGB_W  = `COLOR_RGB_DEPTH;
  localparam int H_DISP = `H_DISP;

  localparam logic [RGB_W-1:0] C_BULLET_COLOR = `BULLET_SINGLE_COLOR;

  // Spawn offsets relative to the plane position, [mode row][lane].
  // Negative y offsets wrap through the slot-width truncation.
  localparam int LANE_X_OFF [3][3] = '{'{14, 0, 0}, '{8, 20, 0}, '{2, 14, 26}};
  localparam int LANE_Y_OFF [3]    = '{0, 2, -4};

  typedef enum logic [1:0] {
    DRIFT_NONE  = 2'd0,
    DRIFT_LEFT  = 2'd1,
    DRIFT_RIGHT = 2'd2
  } drift_e;

  function automatic int lane_count(input logic [1:0] mode);
    case (mode)
      `BULLET_MODE_SINGLE: return 1;
      `BULLET_MODE_DOUBLE: return 2;
      default:             return 3;
    endcase
  endfunction

  // Mode 3 shares the triple-lane table row.
  function automatic int mode_row(input logic [1:0] mode);
    return (mode == 2'd3) ? 2 : int'(mode);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bullet_pool_if.sv
//------------------------------------------------------------------------------
// Module   : bullet_pool_if
// Purpose  : Control, position, kill and pixel-query bundle of bullet_pool.
// Ports    : master drives tick/fire/mode/position/kill/query and receives
//            alpha/rgb/hit/alive/drop; slave is the bullet_pool side.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bullet_pool_if #(
  parameter int BULLET_NUM = 16,
  parameter int IDX_W      = $clog2(BULLET_NUM)
);
  logic                              tick_i;
  logic                              fire_en_i;
  logic [1:0]                        mode_i;
  logic [bullet_pool_pkg::X_W-1:0]   me_x_pos_i;
  logic [bullet_pool_pkg::Y_W-1:0]   me_y_pos_i;
  logic                              kill_valid_i;
  logic [IDX_W-1:0]                  kill_idx_i;
  logic [bullet_pool_pkg::H_LEN-1:0] req_x_addr_i;
  logic [bullet_pool_pkg::V_LEN-1:0] req_y_addr_i;
  logic                              vga_alpha_o;
  logic [bullet_pool_pkg::RGB_W-1:0] vga_rgb_o;
  logic [IDX_W-1:0]                  hit_idx_o;
  logic [IDX_W:0]                    alive_cnt_o;
  logic                              drop_o;

  modport master (
    output tick_i, fire_en_i, mode_i, me_x_pos_i, me_y_pos_i,
           kill_valid_i, kill_idx_i, req_x_addr_i, req_y_addr_i,
    input  vga_alpha_o, vga_rgb_o, hit_idx_o, alive_cnt_o, drop_o
  );

  modport slave (
    input  tick_i, fire_en_i, mode_i, me_x_pos_i, me_y_pos_i,
           kill_valid_i, kill_idx_i, req_x_addr_i, req_y_addr_i,
    output vga_alpha_o, vga_rgb_o, hit_idx_o, alive_cnt_o, drop_o
  );
endinterface

`default_nettype wire

// File: rtl/bullet_pool_free_finder.sv
//------------------------------------------------------------------------------
// Module   : bullet_free_finder
// Purpose  : Combinational search for the three lowest set bits of a free
//            vector, returned in ascending order with per-lane valid bits.
// Ports    : i_free  - 1 = slot free
//            o_idx   - [k] = k-th lowest free slot index
//            o_valid - [k] = o_idx[k] holds a real slot
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bullet_free_finder #(
  parameter int BULLET_NUM = 16,
  parameter int IDX_W      = $clog2(BULLET_NUM)
) (
  input  logic [BULLET_NUM-1:0]   i_free,
  output logic [2:0][IDX_W-1:0]   o_idx,
  output logic [2:0]              o_valid
);

  logic [BULLET_NUM-1:0] w_mask;
  logic [IDX_W-1:0]      w_pick;
  logic                  w_found;

  // Each pass takes the lowest remaining free bit and removes it, so lane k
  // always gets the k-th lowest free slot.
  always_comb begin
    w_mask  = i_free;
    o_idx   = '0;
    o_valid = '0;
    w_pick  = '0;
    w_found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w_pick  = '0;
      w_found = 1'b0;
      for (int i = BULLET_NUM - 1; i >= 0; i--) begin
        if (w_mask[i]) begin
          w_pick  = IDX_W'(i);
          w_found = 1'b1;
        end
      end
      o_idx[k]   = w_pick;
      o_valid[k] = w_found;
      if (w_found) w_mask[w_pick] = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bullet_pool.sv
//------------------------------------------------------------------------------
// Module   : bullet_pool
// Purpose  : Pool of BULLET_NUM player bullets. Auto-fires 1..3 lanes every
//            FIRE_PERIOD cycles into the lowest free slots, moves bullets up
//            SPEED pixels per tick, retires on screen exit or kill, and answers
//            registered VGA pixel queries.
// Ports    : clk, rst (async, active-high)
//            bus (bullet_pool_if.slave): tick/fire/mode/plane position,
//            kill request, pixel query; alpha/rgb/hit index/alive count/drop.
// Options  : BULLET_POOL_SPREAD_EN - triple-mode outer lanes drift one pixel
//            sideways per tick and retire when leaving the visible width.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bullet_pool
  import bullet_pool_pkg::*;
#(
  parameter int BULLET_NUM  = 16,
  parameter int IDX_W       = $clog2(BULLET_NUM),
  parameter int SPEED       = 5,
  parameter int FIRE_PERIOD = 62_500_000,
  parameter int BULLET_W    = `BULLET_WIDTH,
  parameter int BULLET_H    = `BULLET_HEIGHT
) (
  input  logic         clk,
  input  logic         rst,
  bullet_pool_if.slave bus
);

  localparam int CNT_W   = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;
  localparam int ALIVE_W = IDX_W + 1;
  // One extra bit so x+W / y+H never wraps at the right or bottom edge.
  localparam int XC_W    = ((X_W > H_LEN) ? X_W : H_LEN) + 1;
  localparam int YC_W    = ((Y_W > V_LEN) ? Y_W : V_LEN) + 1;

  logic [CNT_W-1:0]      r_fire_cnt;
  logic [BULLET_NUM-1:0] r_visible;
  logic [X_W-1:0]        r_x [BULLET_NUM];
  logic [Y_W-1:0]        r_y [BULLET_NUM];
  logic                  r_alpha;
  logic [RGB_W-1:0]      r_rgb;
  logic [IDX_W-1:0]      r_hit;
  logic [ALIVE_W-1:0]    r_alive;
  logic                  r_drop;

  logic                  w_wrap;
  logic                  w_fire;
  logic [2:0][IDX_W-1:0] w_free_idx;
  logic [2:0]            w_free_valid;
  int                    w_lanes;
  int                    w_row;
  logic [BULLET_NUM-1:0] w_load;
  logic [X_W-1:0]        w_spawn_x [BULLET_NUM];
  logic [Y_W-1:0]        w_spawn_y [BULLET_NUM];
  logic                  w_drop;
  logic [BULLET_NUM-1:0] w_retire;
  logic [X_W-1:0]        w_next_x [BULLET_NUM];
  logic                  w_alpha;
  logic [IDX_W-1:0]      w_hit;
  logic [ALIVE_W-1:0]    w_pop;
`ifdef BULLET_POOL_SPREAD_EN
  drift_e                r_drift [BULLET_NUM];
  drift_e                w_spawn_drift [BULLET_NUM];
`endif

  // Fire timer: held at 0 while disabled, fires on the wrap cycle.
  assign w_wrap = (r_fire_cnt == CNT_W'(FIRE_PERIOD - 1));
  assign w_fire = bus.fire_en_i && w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_fire_cnt <= '0;
    else if (!bus.fire_en_i || w_wrap)  r_fire_cnt <= '0;
    else                                r_fire_cnt <= r_fire_cnt + CNT_W'(1);
  end

  // Free set comes from the registered vector only: a slot retired this
  // cycle is not reused until the next one.
  bullet_free_finder #(.BULLET_NUM(BULLET_NUM), .IDX_W(IDX_W)) u_finder (
    .i_free  (~r_visible),
    .o_idx   (w_free_idx),
    .o_valid (w_free_valid)
  );

  // Lane allocation; missing free slots drop the trailing lanes.
  always_comb begin
    w_lanes = lane_count(bus.mode_i);
    w_row   = mode_row(bus.mode_i);
    w_load  = '0;
    w_drop  = 1'b0;
    for (int i = 0; i < BULLET_NUM; i++) begin
      w_spawn_x[i] = '0;
      w_spawn_y[i] = '0;
`ifdef BULLET_POOL_SPREAD_EN
      w_spawn_drift[i] = DRIFT_NONE;
`endif
    end
    for (int k = 0; k < 3; k++) begin
      if (w_fire && (k < w_lanes)) begin
        if (w_free_valid[k]) begin
          w_load[w_free_idx[k]]    = 1'b1;
          w_spawn_x[w_free_idx[k]] = bus.me_x_pos_i + X_W'(LANE_X_OFF[w_row][k]);
          w_spawn_y[w_free_idx[k]] = bus.me_y_pos_i + Y_W'(LANE_Y_OFF[w_row]);
`ifdef BULLET_POOL_SPREAD_EN
          if (w_row == 2 && k == 0) w_spawn_drift[w_free_idx[k]] = DRIFT_LEFT;
          if (w_row == 2 && k == 2) w_spawn_drift[w_free_idx[k]] = DRIFT_RIGHT;
`endif
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  // Per-slot tick outcome: retire flag and next x.
  always_comb begin
    for (int i = 0; i < BULLET_NUM; i++) begin
      w_retire[i] = (r_y[i] < Y_W'(SPEED));
      w_next_x[i] = r_x[i];
`ifdef BULLET_POOL_SPREAD_EN
      if (r_drift[i] == DRIFT_LEFT) begin
        if (r_x[i] == '0) w_retire[i] = 1'b1;
        else              w_next_x[i] = r_x[i] - X_W'(1);
      end else if (r_drift[i] == DRIFT_RIGHT) begin
        if (r_x[i] >= X_W'(H_DISP - 1)) w_retire[i] = 1'b1;
        else                            w_next_x[i] = r_x[i] + X_W'(1);
      end
`endif
    end
  end

  // Slot state; per-slot priority is kill, then spawn, then tick movement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_visible <= '0;
      for (int i = 0; i < BULLET_NUM; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BULLET_NUM; i++) begin
        if (bus.kill_valid_i && (bus.kill_idx_i == IDX_W'(i))) begin
          r_visible[i] <= 1'b0;
        end else if (w_load[i]) begin
          r_visible[i] <= 1'b1;
          r_x[i]       <= w_spawn_x[i];
          r_y[i]       <= w_spawn_y[i];
        end else if (bus.tick_i && r_visible[i]) begin
          if (w_retire[i]) begin
            r_visible[i] <= 1'b0;
          end else begin
            r_y[i] <= r_y[i] - Y_W'(SPEED);
            r_x[i] <= w_next_x[i];
          end
        end
      end
    end
  end

`ifdef BULLET_POOL_SPREAD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BULLET_NUM; i++) r_drift[i] <= DRIFT_NONE;
    end else begin
      for (int i = 0; i < BULLET_NUM; i++)
        if (w_load[i]) r_drift[i] <= w_spawn_drift[i];
    end
  end
`endif

  // Pixel cover test; descending scan leaves the lowest covering index.
  always_comb begin
    w_alpha = 1'b0;
    w_hit   = '0;
    for (int i = BULLET_NUM - 1; i >= 0; i--) begin
      if (r_visible[i]
          && (XC_W'(r_x[i]) <= XC_W'(bus.req_x_addr_i))
          && (XC_W'(bus.req_x_addr_i) < XC_W'(r_x[i]) + XC_W'(BULLET_W))
          && (YC_W'(r_y[i]) <= YC_W'(bus.req_y_addr_i))
          && (YC_W'(bus.req_y_addr_i) < YC_W'(r_y[i]) + YC_W'(BULLET_H))) begin
        w_alpha = 1'b1;
        w_hit   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < BULLET_NUM; i++) w_pop = w_pop + ALIVE_W'(r_visible[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alpha <= 1'b0;
      r_rgb   <= C_BULLET_COLOR;
      r_hit   <= '0;
      r_alive <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_alpha <= w_alpha;
      r_rgb   <= C_BULLET_COLOR;
      r_hit   <= w_hit;
      r_alive <= w_pop;
      r_drop  <= w_drop;
    end
  end

  assign bus.vga_alpha_o = r_alpha;
  assign bus.vga_rgb_o   = r_rgb;
  assign bus.hit_idx_o   = r_hit;
  assign bus.alive_cnt_o = r_alive;
  assign bus.drop_o      = r_drop;

endmodule

`default_nettype wire
